// File: rtl/stq_adata_mp_if.sv
// Bundles the write, clear, flush and read signals of the store-queue attribute table.
// The master side drives writes, clears, flush and read indices.
// The slave side returns read data, valid flags and the occupancy count.
interface stq_adata_mp_if #(
  parameter int IW = 6,
  parameter int W  = 5,
  parameter int NW = 2,
  parameter int NR = 2
);
  logic [NW-1:0]    wrt_en;
  logic [NW*IW-1:0] wrt_WQ;
  logic [NW*W-1:0]  wrt_adata;
  logic             clr_en;
  logic [IW-1:0]    clr_WQ;
  logic             flush;
  logic [NR*IW-1:0] upd_WQ;
  logic [NR*W-1:0]  upd_adata;
  logic [NR-1:0]    upd_vld;
  logic [IW:0]      occ;

  modport master (
    output wrt_en, wrt_WQ, wrt_adata, clr_en, clr_WQ, flush, upd_WQ,
    input  upd_adata, upd_vld, occ
  );

  modport slave (
    input  wrt_en, wrt_WQ, wrt_adata, clr_en, clr_WQ, flush, upd_WQ,
    output upd_adata, upd_vld, occ
  );
endinterface

// File: rtl/stq_adata_mp.sv
// Multi-port per-store-queue-entry attribute table.
// Each entry holds W bits of data plus a valid bit. Writes set the valid bit,
// a retire clear drops it, and flush drops every valid bit.
// Reads are combinational. With BYPASS set, a read also sees a write made in
// the same cycle. occ tracks the number of valid entries.
module stq_adata_mp #(
  parameter int DEPTH  = 64,
  parameter int IW     = 6,
  parameter int W      = 5,
  parameter int NW     = 2,
  parameter int NR     = 2,
  parameter bit BYPASS = 1'b0
) (
  input logic          clk,
  input logic          rst,
  stq_adata_mp_if.slave bus
);
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  logic [W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [IW:0]      occ_q;
  logic [IW:0]      occ_d;

  logic [IW-1:0]    widx [NW];
  logic [W-1:0]     wdat [NW];
  logic [NW-1:0]    wok;
  logic [NW-1:0]    win;
  logic             clr_ok;
  logic             clr_written;
  logic [IW:0]      add_cnt;

  // Unpack the flat write buses; an index past DEPTH makes that port a no-op.
  always_comb begin
    widx = '{default: '0};
    wdat = '{default: '0};
    wok  = '0;
    for (int p = 0; p < NW; p++) begin
      widx[p] = bus.wrt_WQ[p*IW +: IW];
      wdat[p] = bus.wrt_adata[p*W +: W];
      wok[p]  = bus.wrt_en[p] && ({1'b0, widx[p]} < DEPTH_W);
    end
  end

  // A port wins only if no lower-numbered live port targets the same entry,
  // so the winners always address distinct entries.
  always_comb begin
    win = '0;
    for (int p = 0; p < NW; p++) begin
      win[p] = wok[p];
      for (int q = 0; q < p; q++) begin
        if (wok[q] && (widx[q] == widx[p])) win[p] = 1'b0;
      end
    end
  end

  // Next valid vector and occupancy. The write is applied after the clear so
  // it wins on a shared index. Flush overrides everything.
  always_comb begin
    vld_d       = vld_q;
    add_cnt     = '0;
    clr_written = 1'b0;
    clr_ok      = bus.clr_en && ({1'b0, bus.clr_WQ} < DEPTH_W);
    if (clr_ok) vld_d[bus.clr_WQ] = 1'b0;
    for (int p = 0; p < NW; p++) begin
      if (win[p]) begin
        if (!vld_q[widx[p]]) add_cnt = add_cnt + (IW+1)'(1);
        vld_d[widx[p]] = 1'b1;
        if (clr_ok && (widx[p] == bus.clr_WQ)) clr_written = 1'b1;
      end
    end
    occ_d = occ_q + add_cnt
          - (IW+1)'(clr_ok && vld_q[bus.clr_WQ] && !clr_written);
    if (bus.flush) begin
      vld_d = '0;
      occ_d = '0;
    end
  end

  // Valid bits and occupancy clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  // Data array has no reset; stale contents are hidden by the valid bits.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NW; p++) begin
      if (win[p] && !bus.flush) data_q[widx[p]] <= wdat[p];
    end
  end

  // Combinational read ports. The bypass path forwards the winning same-cycle
  // write, but never during flush or while reset is asserted.
  always_comb begin
    bus.upd_adata = '0;
    bus.upd_vld   = '0;
    for (int r = 0; r < NR; r++) begin
      logic [IW-1:0] ridx;
      logic          hit;
      logic [W-1:0]  val;
      ridx = bus.upd_WQ[r*IW +: IW];
      hit  = ({1'b0, ridx} < DEPTH_W) && vld_q[ridx];
      val  = data_q[ridx];
      if (BYPASS && rst && !bus.flush) begin
        for (int p = NW - 1; p >= 0; p--) begin
          if (win[p] && (widx[p] == ridx)) begin
            hit = 1'b1;
            val = wdat[p];
          end
        end
      end
      bus.upd_vld[r]           = hit;
      bus.upd_adata[r*W +: W]  = hit ? val : '0;
    end
  end

  assign bus.occ = occ_q;

endmodule

// File: tb/tb_stq_adata_mp.sv
// Bench for stq_adata_mp: three instances (DEPTH 64 no bypass, DEPTH 64 with
// bypass, DEPTH 48 no bypass) share one stimulus stream and are compared every
// cycle against a table-level model, plus directed literal scenarios.
module tb_stq_adata_mp;
  localparam int IW = 6;
  localparam int W  = 5;
  localparam int NW = 2;
  localparam int NR = 2;

  logic clk;
  logic rst_n;
  logic [NW-1:0]    wrt_en;
  logic [NW*IW-1:0] wrt_wq;
  logic [NW*W-1:0]  wrt_adata;
  logic             clr_en;
  logic [IW-1:0]    clr_wq;
  logic             flush;
  logic [NR*IW-1:0] upd_wq;

  int total = 0;
  int bad   = 0;

  stq_adata_mp_if #(.IW(IW), .W(W), .NW(NW), .NR(NR)) if0 ();
  stq_adata_mp_if #(.IW(IW), .W(W), .NW(NW), .NR(NR)) if1 ();
  stq_adata_mp_if #(.IW(IW), .W(W), .NW(NW), .NR(NR)) if2 ();

  assign if0.wrt_en = wrt_en;   assign if1.wrt_en = wrt_en;   assign if2.wrt_en = wrt_en;
  assign if0.wrt_WQ = wrt_wq;   assign if1.wrt_WQ = wrt_wq;   assign if2.wrt_WQ = wrt_wq;
  assign if0.wrt_adata = wrt_adata; assign if1.wrt_adata = wrt_adata; assign if2.wrt_adata = wrt_adata;
  assign if0.clr_en = clr_en;   assign if1.clr_en = clr_en;   assign if2.clr_en = clr_en;
  assign if0.clr_WQ = clr_wq;   assign if1.clr_WQ = clr_wq;   assign if2.clr_WQ = clr_wq;
  assign if0.flush = flush;     assign if1.flush = flush;     assign if2.flush = flush;
  assign if0.upd_WQ = upd_wq;   assign if1.upd_WQ = upd_wq;   assign if2.upd_WQ = upd_wq;

  stq_adata_mp #(.DEPTH(64), .IW(IW), .W(W), .NW(NW), .NR(NR), .BYPASS(1'b0))
    u_base (.clk(clk), .rst(rst_n), .bus(if0));
  stq_adata_mp #(.DEPTH(64), .IW(IW), .W(W), .NW(NW), .NR(NR), .BYPASS(1'b1))
    u_byp  (.clk(clk), .rst(rst_n), .bus(if1));
  stq_adata_mp #(.DEPTH(48), .IW(IW), .W(W), .NW(NW), .NR(NR), .BYPASS(1'b0))
    u_d48  (.clk(clk), .rst(rst_n), .bus(if2));

  logic [NR*W-1:0] o_ad  [3];
  logic [NR-1:0]   o_vld [3];
  logic [IW:0]     o_occ [3];
  assign o_ad[0] = if0.upd_adata; assign o_vld[0] = if0.upd_vld; assign o_occ[0] = if0.occ;
  assign o_ad[1] = if1.upd_adata; assign o_vld[1] = if1.upd_vld; assign o_occ[1] = if1.occ;
  assign o_ad[2] = if2.upd_adata; assign o_vld[2] = if2.upd_vld; assign o_occ[2] = if2.occ;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: table 0 is a 64-entry store (instances 0 and 1), table 1 a 48-entry store.
  int         dep [2] = '{64, 48};
  logic [4:0] md  [2][64];
  bit         mv  [2][64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 64; i++) mv[m][i] <= 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (clr_en && int'(clr_wq) < dep[m]) mv[m][clr_wq] <= 1'b0;
        // later non-blocking assignments win: apply highest port first
        for (int p = NW - 1; p >= 0; p--) begin
          if (wrt_en[p] && int'(wrt_wq[p*IW +: IW]) < dep[m]) begin
            md[m][wrt_wq[p*IW +: IW]] <= wrt_adata[p*W +: W];
            mv[m][wrt_wq[p*IW +: IW]] <= 1'b1;
          end
        end
      end
    end
  end

  function automatic int model_occ(input int m);
    int n = 0;
    for (int i = 0; i < dep[m]; i++) if (mv[m][i]) n++;
    return n;
  endfunction

  function automatic void exp_rd(input int i, input int r, output int ev, output int ed);
    int m;
    int idx;
    m   = (i == 2) ? 1 : 0;
    idx = int'(upd_wq[r*IW +: IW]);
    ev  = 0;
    ed  = 0;
    if (!rst_n) return;
    if (i == 1 && !flush) begin
      for (int p = NW - 1; p >= 0; p--) begin
        if (wrt_en[p] && int'(wrt_wq[p*IW +: IW]) == idx) begin
          ev = 1;
          ed = int'(wrt_adata[p*W +: W]);
        end
      end
    end
    if (ev == 0 && idx < dep[m] && mv[m][idx]) begin
      ev = 1;
      ed = int'(md[m][idx]);
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    int ev;
    int ed;
    int m;
    for (int i = 0; i < 3; i++) begin
      m = (i == 2) ? 1 : 0;
      chk($sformatf("occ_i%0d", i), int'(o_occ[i]), model_occ(m));
      chk($sformatf("occ_bound_i%0d", i), int'(int'(o_occ[i]) <= dep[m]), 1);
      for (int r = 0; r < NR; r++) begin
        exp_rd(i, r, ev, ed);
        chk($sformatf("vld_i%0d_r%0d", i, r), int'(o_vld[i][r]), ev);
        chk($sformatf("adata_i%0d_r%0d", i, r), int'(o_ad[i][r*W +: W]), ed);
      end
    end
  endtask

  always @(negedge clk) cmp_all();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrt_en    = '0;
    wrt_wq    = '0;
    wrt_adata = '0;
    clr_en    = 1'b0;
    clr_wq    = '0;
    flush     = 1'b0;
  endtask

  task automatic wr1(input int p, input int idx, input int dat);
    wrt_en[p] = 1'b1;
    wrt_wq[p*IW +: IW] = IW'(idx);
    wrt_adata[p*W +: W] = W'(dat);
  endtask

  initial begin
    logic [IW-1:0] w0, w1, r0, r1;
    rst_n = 1'b0;
    idle();
    upd_wq = '0;
    #12;
    chk("rst_occ", int'(o_occ[0]), 0);
    chk("rst_vld", int'(o_vld[0]), 0);
    chk("rst_adata", int'(o_ad[0]), 0);
    #10 rst_n = 1'b1;
    step();

    // write WQ=5 -> 0x1A, then read 5 and 6
    wr1(0, 5, 'h1A);
    upd_wq = {6'd6, 6'd5};
    step();
    idle();
    #1;
    chk("wr5_adata", int'(o_ad[0][4:0]), 'h1A);
    chk("wr5_vld", int'(o_vld[0][0]), 1);
    chk("wr5_occ", int'(o_occ[0]), 1);
    chk("rd6_adata", int'(o_ad[0][9:5]), 0);
    chk("rd6_vld", int'(o_vld[0][1]), 0);

    // both ports hit index 9: port 0 wins, counted once
    wr1(0, 9, 'h03);
    wr1(1, 9, 'h1F);
    upd_wq = {6'd0, 6'd9};
    step();
    idle();
    #1;
    chk("coll_adata", int'(o_ad[0][4:0]), 'h03);
    chk("coll_occ", int'(o_occ[0]), 2);

    // same-cycle read of a write: bypass instance forwards, base does not
    wr1(0, 12, 'h11);
    upd_wq = {6'd12, 6'd0};
    #1;
    chk("byp_adata", int'(o_ad[1][9:5]), 'h11);
    chk("byp_vld", int'(o_vld[1][1]), 1);
    chk("nobyp_vld", int'(o_vld[0][1]), 0);
    step();
    idle();
    #1;
    chk("nobyp_next_adata", int'(o_ad[0][9:5]), 'h11);
    chk("nobyp_next_vld", int'(o_vld[0][1]), 1);

    // out-of-range index on the 48-entry instance
    wr1(0, 50, 'h07);
    upd_wq = {6'd0, 6'd50};
    step();
    idle();
    #1;
    chk("d48_occ", int'(o_occ[2]), 3);
    chk("d48_vld", int'(o_vld[2][0]), 0);
    chk("d48_adata", int'(o_ad[2][4:0]), 0);
    chk("d64_wq50_adata", int'(o_ad[0][4:0]), 'h07);

    // fill every entry, two per cycle
    for (int c = 0; c < 32; c++) begin
      wr1(0, 2*c, int'($urandom_range(0, 31)));
      wr1(1, 2*c + 1, int'($urandom_range(0, 31)));
      step();
    end
    idle();
    #1;
    chk("fill_occ64", int'(o_occ[0]), 64);
    chk("fill_occ48", int'(o_occ[2]), 48);

    // clear and write entry 0 in one cycle: write wins
    wr1(0, 0, 'h0A);
    clr_en = 1'b1;
    clr_wq = 6'd0;
    upd_wq = {6'd0, 6'd0};
    step();
    idle();
    #1;
    chk("clrwr_occ", int'(o_occ[0]), 64);
    chk("clrwr_vld", int'(o_vld[0][0]), 1);
    chk("clrwr_adata", int'(o_ad[0][4:0]), 'h0A);

    // flush drops the accompanying write
    flush = 1'b1;
    wr1(0, 3, 'h15);
    upd_wq = {6'd0, 6'd3};
    step();
    idle();
    #1;
    chk("flush_occ", int'(o_occ[0]), 0);
    chk("flush_vld", int'(o_vld[0][0]), 0);

    // bring occ to 7, then reset between edges
    for (int c = 0; c < 4; c++) begin
      wr1(0, 10 + 2*c, c);
      if (c < 3) wr1(1, 11 + 2*c, c + 8);
      step();
      idle();
    end
    chk("pre_rst_occ", int'(o_occ[0]), 7);
    upd_wq = {6'd11, 6'd10};
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_occ", int'(o_occ[0]), 0);
    chk("async_rst_vld0", int'(o_vld[0]), 0);
    chk("async_rst_vld1", int'(o_vld[1]), 0);
    rst_n = 1'b1;
    wr1(0, 2, 'h05);
    step();
    idle();
    #1;
    chk("post_rst_occ", int'(o_occ[0]), 1);

    // randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      w0 = IW'($urandom_range(0, 63));
      w1 = ($urandom_range(0, 3) == 0) ? w0 : IW'($urandom_range(0, 63));
      wrt_en    = NW'($urandom_range(0, 3));
      wrt_wq    = {w1, w0};
      wrt_adata = (NW*W)'($urandom);
      clr_en    = ($urandom_range(0, 2) == 0);
      clr_wq    = ($urandom_range(0, 1) == 0) ? w0 : IW'($urandom_range(0, 63));
      flush     = ($urandom_range(0, 99) == 0);
      r0 = IW'($urandom_range(0, 63));
      r1 = ($urandom_range(0, 1) == 0) ? w0 : IW'($urandom_range(0, 63));
      upd_wq = {r1, r0};
      step();
    end
    idle();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
